atri_readout_sequencer: RTL

- Micro-sequencer that fetches and executes the 18-bit readout instruction words held in the readout instruction ROM.
- Drives the ROM address and consumes the instruction one clock later; the ROM is a synchronous BRAM with 1-cycle read latency.
- Produces port-write strobes toward the readout control registers and waits on external condition bits.
- Sits directly downstream of the ROM and upstream of the readout register bank.

---
 rtl/atri_readout_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/atri_readout_sequencer.sv
// Readout micro-sequencer: fetches 18-bit instruction words from a
// synchronous ROM (1-cycle read latency), executes them and emits
// port-write strobes toward the readout control register bank.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | halted; PC parked at START_ADDR, waits for start_i
// FETCH  | ROM address (PC) stable, instruction word arrives next cycle
// EXEC   | decode rom_data_i, update PC / counter / stack, emit strobes
// WAITC  | stalled on a WAIT until the latched condition holds
module atri_readout_sequencer #(
    parameter logic [9:0] START_ADDR  = 10'h000,
    parameter int         STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic [9:0]  rom_addr_o,
    input  logic [17:0] rom_data_i,
    input  logic [7:0]  cond_i,
    output logic [5:0]  out_port_o,
    output logic [7:0]  out_data_o,
    output logic        out_wr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // One extra pointer bit so "full" (== STACK_DEPTH) is representable.
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JUMP = 4'd1;
    localparam logic [3:0] OP_CALL = 4'd2;
    localparam logic [3:0] OP_RET  = 4'd3;
    localparam logic [3:0] OP_LDC  = 4'd4;
    localparam logic [3:0] OP_DJNZ = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_WAIT = 4'd7;
    localparam logic [3:0] OP_END  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WAITC
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [13:0]       cnt_q, cnt_d;
    logic [2:0]        wait_sel_q, wait_sel_d;
    logic              wait_pol_q, wait_pol_d;
    logic [5:0]        out_port_q, out_port_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_wr_q, out_wr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              push_en;
    logic              go_idle;
    logic [9:0]        stack_q [STACK_DEPTH];

    logic [3:0]        op;
    logic [13:0]       operand;
    logic [9:0]        op_addr;
    logic [9:0]        pc_inc;
    logic [13:0]       cnt_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              stack_full;
    logic              stack_empty;
    logic              cond_exec;
    logic              cond_wait;

    // Instruction field split and shared arithmetic.
    always_comb begin
        op          = rom_data_i[17:14];
        operand     = rom_data_i[13:0];
        op_addr     = rom_data_i[9:0];
        pc_inc      = pc_q + 10'd1;
        cnt_dec     = cnt_q - 14'd1;
        push_idx    = sp_q[IDX_W-1:0];
        top_idx     = sp_q[IDX_W-1:0] - IDX_W'(1);
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == '0);
        // EXEC evaluates the condition straight from the instruction word;
        // WAITC uses the copy latched during EXEC.
        cond_exec   = (cond_i[rom_data_i[2:0]] == rom_data_i[3]);
        cond_wait   = (cond_i[wait_sel_q] == wait_pol_q);
    end

    // Next-state, datapath update and strobe generation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        wait_sel_d = wait_sel_q;
        wait_pol_d = wait_pol_q;
        out_port_d = out_port_q;
        out_data_d = out_data_q;
        out_wr_d   = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        push_en    = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_d    = START_ADDR;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_NOP: begin
                        pc_d = pc_inc;
                    end
                    OP_JUMP: begin
                        pc_d = op_addr;
                    end
                    OP_CALL: begin
                        if (stack_full) begin
                            error_d = 1'b1;
                            go_idle = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                            pc_d    = op_addr;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            error_d = 1'b1;
                            go_idle = 1'b1;
                        end else begin
                            sp_d = sp_q - SP_W'(1);
                            pc_d = stack_q[top_idx];
                        end
                    end
                    OP_LDC: begin
                        cnt_d = operand;
                        pc_d  = pc_inc;
                    end
                    OP_DJNZ: begin
                        cnt_d = cnt_dec;
                        pc_d  = (cnt_dec != 14'd0) ? op_addr : pc_inc;
                    end
                    OP_OUT: begin
                        out_port_d = rom_data_i[13:8];
                        out_data_d = rom_data_i[7:0];
                        out_wr_d   = 1'b1;
                        pc_d       = pc_inc;
                    end
                    OP_WAIT: begin
                        wait_sel_d = rom_data_i[2:0];
                        wait_pol_d = rom_data_i[3];
                        if (cond_exec) begin
                            pc_d = pc_inc;
                        end else begin
                            state_d = ST_WAITC;
                        end
                    end
                    OP_END: begin
                        done_d  = 1'b1;
                        go_idle = 1'b1;
                    end
                    default: begin
                        error_d = 1'b1;
                        go_idle = 1'b1;
                    end
                endcase
            end

            ST_WAITC: begin
                if (cond_wait) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Every return to IDLE re-parks the ROM address and empties the stack.
        if (go_idle) begin
            state_d = ST_IDLE;
            pc_d    = START_ADDR;
            sp_d    = '0;
        end
    end

    // State, PC, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_ADDR;
            sp_q       <= '0;
            cnt_q      <= '0;
            wait_sel_q <= '0;
            wait_pol_q <= 1'b0;
            out_port_q <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            wait_sel_q <= wait_sel_d;
            wait_pol_q <= wait_pol_d;
            out_port_q <= out_port_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Return-address storage; validity is tracked by sp_q, so no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign rom_addr_o = pc_q;
    assign out_port_o = out_port_q;
    assign out_data_o = out_data_q;
    assign out_wr_o   = out_wr_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
